vga_scanout: RTL and testbench
==============================

Name: vga_scanout

Overview:
- Parametrised next-generation VGA scan-out engine. Generates raster timing, framebuffer read addressing and sync/enable outputs, all in the pixel clock domain.
- Adds the following to the current generation:
  - N-way framebuffer ring with request/acknowledge swap at vblank.
  - Integer pixel replication (2^SCALE_SHIFT).
  - Configurable RAM-latency compensation pipeline.
  - Frame counter and frame-start strobe.
- Sits between the framebuffer RAM read port and the palette/colour stage.

Parameters:
- COOR_WIDTH, 12: coordinate counter width
- HSIZE/HFP/HSP/HMAX, 1280/1344/1480/1680: horizontal active, front-porch end, sync end, total
- VSIZE/VFP/VSP/VMAX, 800/801/804/828: vertical equivalents
- HSPP/VSPP, 1/1: active sync polarity
- FRAME_LEFT/FRAME_RIGHT/FRAME_TOP/FRAME_BOTTOM, 0/1280/250/550: window bounds, screen pixels, right/bottom exclusive
- SCALE_SHIFT, 0: each stored pixel covers 2^SCALE_SHIFT x 2^SCALE_SHIFT screen pixels
- NUM_PARTS, 2: framebuffer parts in the ring, >=2
- ADDR_WIDTH, 20: RAM address width
- PIX_WIDTH, 2: palette index width
- PIPE_DEPTH, 4: counter-to-output delay, >=2; RAM read latency must equal PIPE_DEPTH-1
- FRAME_CNT_WIDTH, 16: frame counter width

Ports:
- clk_vga, input, 1: pixel clock
- rst, input, 1: asynchronous, active-high reset
- swap_req, input, 1: producer finished writing write_part; one-cycle pulse or level
- swap_ack, output, 1: one-cycle pulse when swap performed
- read_part, output, clog2(NUM_PARTS): part being displayed
- write_part, output, clog2(NUM_PARTS): (read_part+1) mod NUM_PARTS
- read_addr, output, ADDR_WIDTH: RAM read address
- read_enable, output, 1: RAM read enable
- read_pixel, input, PIX_WIDTH: RAM read data
- hsync, output, 1: horizontal sync
- vsync, output, 1: vertical sync
- data_enable, output, 1: active video
- in_frame, output, 1: pixel_out is framebuffer data
- pixel_out, output, PIX_WIDTH: palette index
- frame_start, output, 1: one-cycle strobe, first active pixel
- frame_count, output, FRAME_CNT_WIDTH: completed frames, wraps

Behaviour:
- Raster counter:
  - x counts 0..HMAX-1; at HMAX-1 it wraps to 0 and y increments.
  - y wraps VMAX-1 -> 0.
  - Reset sets (x,y) = (0,0).
- Delay line:
  - PIPE_DEPTH-1 stages carrying (x, y, valid).
  - valid is cleared on reset and shifts in 1 thereafter.
- Registered outputs:
  - hsync, vsync, data_enable, in_frame, pixel_out and frame_start are registered from the last delay stage.
  - Total latency from counter to outputs is PIPE_DEPTH cycles.
  - read_pixel is sampled on the same edge that registers the outputs.
  - If the last stage is invalid, outputs hold their reset values.
- Reset values:
  - hsync = !HSPP, vsync = !VSPP.
  - data_enable, in_frame, pixel_out, frame_start, swap_ack, read_part, frame_count = 0.
- Timing:
  - hsync = HSPP when HFP <= x < HSP.
  - vsync = VSPP when VFP <= y < VSP.
  - data_enable = (x < HSIZE) && (y < VSIZE).
- Read addressing, combinational from the counter (stage 0):
  - Window test: FRAME_LEFT <= x < FRAME_RIGHT and FRAME_TOP <= y < FRAME_BOTTOM.
  - Derived sizes: FB_W = (FRAME_RIGHT-FRAME_LEFT)>>SCALE_SHIFT, FB_H likewise; PART_SIZE = FB_W*FB_H.
  - Local coordinates: lx = (x-FRAME_LEFT)>>SCALE_SHIFT, ly = (y-FRAME_TOP)>>SCALE_SHIFT.
  - Address: read_addr = read_part*PART_SIZE + ly*FB_W + lx, truncated to ADDR_WIDTH.
  - Outside the window: read_enable = 0, read_addr = 0.
- Output pixel:
  - In window and active: pixel_out = read_pixel, in_frame = 1.
  - Active but outside window: pixel_out = 0, in_frame = 0.
  - Blanking: pixel_out = 0, in_frame = 0.
- Swap point is counter (x,y) = (0,VSIZE):
  - swap_pending is set by swap_req and cleared by a swap.
  - A swap occurs at the swap point if swap_pending or swap_req is high.
  - On a swap: read_part <= (read_part+1) mod NUM_PARTS and swap_ack pulses for 1 cycle.
  - swap_req arriving in the swap cycle is consumed by that swap.
  - Further requests while pending collapse into one.
  - The ring wraps NUM_PARTS-1 -> 0.
- frame_count increments at every swap point, swap or not, wrapping at 2^FRAME_CNT_WIDTH.
- frame_start = 1 for the single cycle whose registered outputs correspond to (0,0).
- Reset mid-frame: all state, including swap_pending, returns to reset values immediately; no partial swap.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined:
  - Adds input test_mode, 1 bit.
  - When test_mode = 1 during active video: pixel_out = ((x>>4) ^ (y>>4)) mod 2^PIX_WIDTH, in_frame = 1, read_enable forced 0.
  - When test_mode = 0: behaviour as without the macro.
- Undefined: no test_mode port; behaviour exactly as described above.

Test Plan:
- Reset release with defaults: first data_enable rise PIPE_DEPTH=4 edges after release, coinciding with frame_start.
- Sync timing: hsync high for 136 cycles per 1680-cycle line; vsync high for 3 lines of 828; data_enable low whenever x>=1280 or y>=800.
- Addressing, defaults with SCALE_SHIFT=0, read_part=0:
  - Counter (5,250) -> read_addr 5.
  - (0,251) -> 1280.
  - (0,249) -> read_enable 0.
  - After one swap, (5,250) -> 384005.
- SCALE_SHIFT=1: counter (2,252) and (3,253) both -> read_addr 641; FB_W = 640.
- Swap handling, NUM_PARTS=3:
  - Pulse swap_req mid-frame -> one swap_ack at the next (0,800); read_part 0->1.
  - Three more frames with a request each -> 2, 0, 1.
  - Request in the swap cycle itself is honoured.
  - No request -> read_part unchanged while frame_count still increments.
- Assert rst at counter (700,400) with swap pending -> outputs return to reset values at once; no swap_ack after release until a new swap_req.

Source files
------------

// File: rtl/vga_scanout.sv
// Raster scan-out engine: timing counters, framebuffer-ring read addressing and registered sync/pixel outputs.
// Defining VGA_TEST_PATTERN_EN adds a test_mode input that replaces active video with a checkerboard pattern.
module vga_scanout #(
    parameter int COOR_WIDTH      = 12,
    parameter int HSIZE           = 1280,
    parameter int HFP             = 1344,
    parameter int HSP             = 1480,
    parameter int HMAX            = 1680,
    parameter int VSIZE           = 800,
    parameter int VFP             = 801,
    parameter int VSP             = 804,
    parameter int VMAX            = 828,
    parameter int HSPP            = 1,
    parameter int VSPP            = 1,
    parameter int FRAME_LEFT      = 0,
    parameter int FRAME_RIGHT     = 1280,
    parameter int FRAME_TOP       = 250,
    parameter int FRAME_BOTTOM    = 550,
    parameter int SCALE_SHIFT     = 0,
    parameter int NUM_PARTS       = 2,
    parameter int ADDR_WIDTH      = 20,
    parameter int PIX_WIDTH       = 2,
    parameter int PIPE_DEPTH      = 4,
    parameter int FRAME_CNT_WIDTH = 16,
    localparam int PART_W         = (NUM_PARTS > 1) ? $clog2(NUM_PARTS) : 1
) (
    input  logic                       clk_vga,
    input  logic                       rst,
    input  logic                       swap_req,
    output logic                       swap_ack,
    output logic [PART_W-1:0]          read_part,
    output logic [PART_W-1:0]          write_part,
    output logic [ADDR_WIDTH-1:0]      read_addr,
    output logic                       read_enable,
    input  logic [PIX_WIDTH-1:0]       read_pixel,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       data_enable,
    output logic                       in_frame,
    output logic [PIX_WIDTH-1:0]       pixel_out,
    output logic                       frame_start,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count
`ifdef VGA_TEST_PATTERN_EN
    ,
    input  logic                       test_mode
`endif
);

    typedef logic [COOR_WIDTH-1:0] coor_t;

    typedef struct packed {
        logic  valid;
        coor_t x;
        coor_t y;
        logic  win;
    } stage_t;

    localparam coor_t C_HLAST  = coor_t'(HMAX - 1);
    localparam coor_t C_VLAST  = coor_t'(VMAX - 1);
    localparam coor_t C_HSIZE  = coor_t'(HSIZE);
    localparam coor_t C_VSIZE  = coor_t'(VSIZE);
    localparam coor_t C_HFP    = coor_t'(HFP);
    localparam coor_t C_HSP    = coor_t'(HSP);
    localparam coor_t C_VFP    = coor_t'(VFP);
    localparam coor_t C_VSP    = coor_t'(VSP);
    localparam coor_t C_LEFT   = coor_t'(FRAME_LEFT);
    localparam coor_t C_RIGHT  = coor_t'(FRAME_RIGHT);
    localparam coor_t C_TOP    = coor_t'(FRAME_TOP);
    localparam coor_t C_BOTTOM = coor_t'(FRAME_BOTTOM);

    localparam int FB_W      = (FRAME_RIGHT - FRAME_LEFT) >> SCALE_SHIFT;
    localparam int PART_SIZE = FB_W * ((FRAME_BOTTOM - FRAME_TOP) >> SCALE_SHIFT);

    localparam logic HS_ON = (HSPP != 0);
    localparam logic VS_ON = (VSPP != 0);
    localparam logic [PART_W-1:0] P_LAST = PART_W'(NUM_PARTS - 1);

    coor_t                 x_reg;
    coor_t                 y_reg;
    logic                  swap_pending_reg;
    logic [ADDR_WIDTH-1:0] base_reg;
    stage_t                pipe_reg [1:PIPE_DEPTH-1];

    logic [COOR_WIDTH:0]   dx;
    logic [COOR_WIDTH:0]   dy;
    coor_t                 lx;
    coor_t                 ly;
    logic                  win0;
    logic                  at_swap;
    stage_t                stage0;
    stage_t                last_stage;

    logic                  active_last;
    logic                  in_frame_next;
    logic [PIX_WIDTH-1:0]  pixel_next;

    // Raster counter
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (x_reg == C_HLAST) begin
            x_reg <= '0;
            y_reg <= (y_reg == C_VLAST) ? '0 : y_reg + coor_t'(1);
        end else begin
            x_reg <= x_reg + coor_t'(1);
        end
    end

    // The borrow out of the offset subtraction doubles as the left/top window test.
    assign dx   = {1'b0, x_reg} - {1'b0, C_LEFT};
    assign dy   = {1'b0, y_reg} - {1'b0, C_TOP};
    assign lx   = dx[COOR_WIDTH-1:0] >> SCALE_SHIFT;
    assign ly   = dy[COOR_WIDTH-1:0] >> SCALE_SHIFT;
    assign win0 = !dx[COOR_WIDTH] && (x_reg < C_RIGHT) &&
                  !dy[COOR_WIDTH] && (y_reg < C_BOTTOM);

    assign read_addr = win0 ? (base_reg + ADDR_WIDTH'(ly) * ADDR_WIDTH'(FB_W) + ADDR_WIDTH'(lx))
                            : '0;
`ifdef VGA_TEST_PATTERN_EN
    assign read_enable = win0 && !test_mode;
`else
    assign read_enable = win0;
`endif

    assign stage0     = {1'b1, x_reg, y_reg, win0};
    assign last_stage = pipe_reg[PIPE_DEPTH-1];

    // Delay line matches the RAM read latency so coordinates and pixel data line up.
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                pipe_reg[i] <= '0;
            end
        end else begin
            pipe_reg[1] <= stage0;
            for (int i = 2; i < PIPE_DEPTH; i++) begin
                pipe_reg[i] <= pipe_reg[i-1];
            end
        end
    end

    always_comb begin
        active_last   = (last_stage.x < C_HSIZE) && (last_stage.y < C_VSIZE);
        in_frame_next = active_last && last_stage.win;
        pixel_next    = in_frame_next ? read_pixel : '0;
`ifdef VGA_TEST_PATTERN_EN
        if (test_mode && active_last) begin
            in_frame_next = 1'b1;
            pixel_next    = PIX_WIDTH'((last_stage.x >> 4) ^ (last_stage.y >> 4));
        end
`endif
    end

    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            hsync       <= !HS_ON;
            vsync       <= !VS_ON;
            data_enable <= 1'b0;
            in_frame    <= 1'b0;
            pixel_out   <= '0;
            frame_start <= 1'b0;
        end else if (!last_stage.valid) begin
            hsync       <= !HS_ON;
            vsync       <= !VS_ON;
            data_enable <= 1'b0;
            in_frame    <= 1'b0;
            pixel_out   <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= ((last_stage.x >= C_HFP) && (last_stage.x < C_HSP)) ? HS_ON : !HS_ON;
            vsync       <= ((last_stage.y >= C_VFP) && (last_stage.y < C_VSP)) ? VS_ON : !VS_ON;
            data_enable <= active_last;
            in_frame    <= in_frame_next;
            pixel_out   <= pixel_next;
            frame_start <= (last_stage.x == '0) && (last_stage.y == '0);
        end
    end

    // Swap point sits at the start of vertical blanking, after the last active line was fetched.
    assign at_swap    = (x_reg == '0) && (y_reg == C_VSIZE);
    assign write_part = (read_part == P_LAST) ? '0 : read_part + PART_W'(1);

    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            swap_pending_reg <= 1'b0;
            read_part        <= '0;
            base_reg         <= '0;
            swap_ack         <= 1'b0;
            frame_count      <= '0;
        end else begin
            swap_ack <= 1'b0;
            if (at_swap) begin
                frame_count <= frame_count + FRAME_CNT_WIDTH'(1);
                if (swap_pending_reg || swap_req) begin
                    swap_ack         <= 1'b1;
                    swap_pending_reg <= 1'b0;
                    if (read_part == P_LAST) begin
                        read_part <= '0;
                        base_reg  <= '0;
                    end else begin
                        read_part <= read_part + PART_W'(1);
                        base_reg  <= base_reg + ADDR_WIDTH'(PART_SIZE);
                    end
                end
            end else if (swap_req) begin
                swap_pending_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: two small-raster instances (unscaled 3-part ring, 2x-scaled 2-part ring)
// checked every cycle against a frame-position model, plus address vectors and reset/swap sequences.
module tb_vga_scanout;

    localparam int HSIZE = 16, HFP = 18, HSP = 21, HMAX = 24;
    localparam int VSIZE = 10, VFP = 11, VSP = 13, VMAX = 14;
    localparam int HSPP = 1, VSPP = 0;
    localparam int FL = 2, FR = 14, FT = 2, FB = 8;
    localparam int NPA = 3, NPB = 2, PIPE = 4, FCW = 4;
    localparam int FRAME = HMAX * VMAX;
    localparam int SWAP_POS = VSIZE * HMAX;
    localparam int FBW_A = FR - FL;
    localparam int PART_A = FBW_A * (FB - FT);
    localparam int FBW_B = (FR - FL) >> 1;
    localparam int PART_B = FBW_B * ((FB - FT) >> 1);

    typedef struct {
        logic       hs;
        logic       vs;
        logic       de;
        logic       inf;
        logic       fs;
        logic [1:0] pix;
    } exp_t;

    typedef struct {
        int frame;
        int x;
        int y;
        bit on_b;
        bit en;
        int addr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        swap_req = 1'b0;

    logic        a_swap_ack, a_read_enable, a_hsync, a_vsync, a_de, a_inf, a_fs;
    logic [1:0]  a_read_part, a_write_part, a_pix, a_read_pixel;
    logic [19:0] a_read_addr;
    logic [3:0]  a_frame_count;

    logic        b_swap_ack, b_read_enable, b_hsync, b_vsync, b_de, b_inf, b_fs;
    logic [0:0]  b_read_part, b_write_part;
    logic [1:0]  b_pix;
    logic [19:0] b_read_addr;
    logic [3:0]  b_frame_count;

    logic [1:0]  mem [0:255];
    logic [1:0]  ram_q1 = 2'b00, ram_q2 = 2'b00, ram_q3 = 2'b00;

    exp_t        hist [0:7];
    vec_t        tab [$];
    int          k, nswap, fcount, total, bad;
    bit          req_seen, ack_exp, tab_on;

    always #5 clk = ~clk;

    // Framebuffer RAM with PIPE-1 cycles of read latency.
    always @(posedge clk) begin
        if (a_read_enable) ram_q1 <= mem[a_read_addr[7:0]];
        ram_q2 <= ram_q1;
        ram_q3 <= ram_q2;
    end
    assign a_read_pixel = ram_q3;

    vga_scanout #(
        .COOR_WIDTH(8), .HSIZE(HSIZE), .HFP(HFP), .HSP(HSP), .HMAX(HMAX),
        .VSIZE(VSIZE), .VFP(VFP), .VSP(VSP), .VMAX(VMAX), .HSPP(HSPP), .VSPP(VSPP),
        .FRAME_LEFT(FL), .FRAME_RIGHT(FR), .FRAME_TOP(FT), .FRAME_BOTTOM(FB),
        .SCALE_SHIFT(0), .NUM_PARTS(NPA), .ADDR_WIDTH(20), .PIX_WIDTH(2),
        .PIPE_DEPTH(PIPE), .FRAME_CNT_WIDTH(FCW)
    ) dut_a (
        .clk_vga(clk), .rst(rst), .swap_req(swap_req), .swap_ack(a_swap_ack),
        .read_part(a_read_part), .write_part(a_write_part), .read_addr(a_read_addr),
        .read_enable(a_read_enable), .read_pixel(a_read_pixel), .hsync(a_hsync),
        .vsync(a_vsync), .data_enable(a_de), .in_frame(a_inf), .pixel_out(a_pix),
        .frame_start(a_fs), .frame_count(a_frame_count)
`ifdef VGA_TEST_PATTERN_EN
        , .test_mode(1'b0)
`endif
    );

    vga_scanout #(
        .COOR_WIDTH(8), .HSIZE(HSIZE), .HFP(HFP), .HSP(HSP), .HMAX(HMAX),
        .VSIZE(VSIZE), .VFP(VFP), .VSP(VSP), .VMAX(VMAX), .HSPP(HSPP), .VSPP(VSPP),
        .FRAME_LEFT(FL), .FRAME_RIGHT(FR), .FRAME_TOP(FT), .FRAME_BOTTOM(FB),
        .SCALE_SHIFT(1), .NUM_PARTS(NPB), .ADDR_WIDTH(20), .PIX_WIDTH(2),
        .PIPE_DEPTH(PIPE), .FRAME_CNT_WIDTH(FCW)
    ) dut_b (
        .clk_vga(clk), .rst(rst), .swap_req(swap_req), .swap_ack(b_swap_ack),
        .read_part(b_read_part), .write_part(b_write_part), .read_addr(b_read_addr),
        .read_enable(b_read_enable), .read_pixel(2'b00), .hsync(b_hsync),
        .vsync(b_vsync), .data_enable(b_de), .in_frame(b_inf), .pixel_out(b_pix),
        .frame_start(b_fs), .frame_count(b_frame_count)
`ifdef VGA_TEST_PATTERN_EN
        , .test_mode(1'b0)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at k=%0d: got %0h, want %0h", name, k, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_hsync"}, 32'(a_hsync), 32'(HSPP == 0));
        chk({tag, "_vsync"}, 32'(a_vsync), 32'(VSPP == 0));
        chk({tag, "_de"}, 32'({a_de, a_inf, a_fs, a_swap_ack}), 0);
        chk({tag, "_pix"}, 32'(a_pix), 0);
        chk({tag, "_part"}, 32'(a_read_part), 0);
        chk({tag, "_fcount"}, 32'(a_frame_count), 0);
        chk({tag, "_rd"}, 32'({a_read_enable, a_read_addr}), 0);
        chk({tag, "_b_state"}, 32'({b_de, b_inf, b_fs, b_swap_ack, b_read_part, b_frame_count}), 0);
    endtask

    task automatic model_reset();
        k = 0;
        nswap = 0;
        fcount = 0;
        req_seen = 1'b0;
        ack_exp = 1'b0;
    endtask

    // Check the state after k edges, then drive swap_req for the coming cycle and advance the model.
    task automatic run_cycle(input logic req);
        int   pos, x, y, pa, pb;
        bit   win, de;
        exp_t e, o;
        pos = k % FRAME;
        x = pos % HMAX;
        y = pos / HMAX;
        win = (x >= FL) && (x < FR) && (y >= FT) && (y < FB);
        de = (x < HSIZE) && (y < VSIZE);
        pa = win ? (nswap % NPA) * PART_A + (y - FT) * FBW_A + (x - FL) : 0;
        pb = win ? (nswap % NPB) * PART_B + ((y - FT) >> 1) * FBW_B + ((x - FL) >> 1) : 0;
        e.hs = ((x >= HFP) && (x < HSP)) ? (HSPP != 0) : (HSPP == 0);
        e.vs = ((y >= VFP) && (y < VSP)) ? (VSPP != 0) : (VSPP == 0);
        e.de = de;
        e.inf = de && win;
        e.pix = (de && win) ? mem[pa] : 2'b00;
        e.fs = (pos == 0);
        hist[k % 8] = e;
        if (k >= PIPE) begin
            o = hist[(k - PIPE) % 8];
        end else begin
            o.hs = (HSPP == 0); o.vs = (VSPP == 0);
            o.de = 1'b0; o.inf = 1'b0; o.fs = 1'b0; o.pix = 2'b00;
        end

        chk("a_read_enable", 32'(a_read_enable), 32'(win));
        chk("a_read_addr", 32'(a_read_addr), pa);
        chk("a_read_part", 32'(a_read_part), nswap % NPA);
        chk("a_write_part", 32'(a_write_part), (nswap + 1) % NPA);
        chk("a_swap_ack", 32'(a_swap_ack), 32'(ack_exp));
        chk("a_frame_count", 32'(a_frame_count), fcount % (1 << FCW));
        chk("a_hsync", 32'(a_hsync), 32'(o.hs));
        chk("a_vsync", 32'(a_vsync), 32'(o.vs));
        chk("a_data_enable", 32'(a_de), 32'(o.de));
        chk("a_in_frame", 32'(a_inf), 32'(o.inf));
        chk("a_pixel_out", 32'(a_pix), 32'(o.pix));
        chk("a_frame_start", 32'(a_fs), 32'(o.fs));
        chk("b_read_enable", 32'(b_read_enable), 32'(win));
        chk("b_read_addr", 32'(b_read_addr), pb);
        chk("b_parts", 32'({b_read_part, b_write_part}), 32'({1'(nswap % NPB), 1'((nswap + 1) % NPB)}));
        chk("b_swap_ack", 32'(b_swap_ack), 32'(ack_exp));
        chk("b_frame_count", 32'(b_frame_count), fcount % (1 << FCW));
        chk("b_sync", 32'({b_hsync, b_vsync, b_de, b_fs}), 32'({o.hs, o.vs, o.de, o.fs}));
        chk("b_pixel", 32'({b_inf, b_pix}), 32'({o.inf, 2'b00}));

        if (tab_on) begin
            foreach (tab[i]) begin
                if (tab[i].frame == k / FRAME && tab[i].x == x && tab[i].y == y) begin
                    if (tab[i].on_b) begin
                        chk($sformatf("vec%0d_b_en", i), 32'(b_read_enable), 32'(tab[i].en));
                        chk($sformatf("vec%0d_b_addr", i), 32'(b_read_addr), tab[i].addr);
                    end else begin
                        chk($sformatf("vec%0d_a_en", i), 32'(a_read_enable), 32'(tab[i].en));
                        chk($sformatf("vec%0d_a_addr", i), 32'(a_read_addr), tab[i].addr);
                    end
                end
            end
        end

        swap_req = req;
        ack_exp = 1'b0;
        if (pos == SWAP_POS) begin
            fcount++;
            if (req_seen || req) begin
                nswap++;
                ack_exp = 1'b1;
            end
            req_seen = 1'b0;
        end else begin
            req_seen = req_seen || req;
        end
        k++;
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached at k=%0d", k);
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad = 0;
        tab_on = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 2'($urandom_range(0, 3));

        // {frame, x, y, instance B?, read_enable, read_addr}
        tab.push_back(vec_t'{0, 5, 2, 1'b0, 1'b1, 3});
        tab.push_back(vec_t'{0, 2, 3, 1'b0, 1'b1, 12});
        tab.push_back(vec_t'{0, 13, 7, 1'b0, 1'b1, 71});
        tab.push_back(vec_t'{0, 2, 1, 1'b0, 1'b0, 0});
        tab.push_back(vec_t'{0, 14, 5, 1'b0, 1'b0, 0});
        tab.push_back(vec_t'{0, 1, 4, 1'b0, 1'b0, 0});
        tab.push_back(vec_t'{0, 4, 8, 1'b0, 1'b0, 0});
        tab.push_back(vec_t'{1, 5, 2, 1'b0, 1'b1, 75});
        tab.push_back(vec_t'{1, 13, 7, 1'b0, 1'b1, 143});
        tab.push_back(vec_t'{0, 2, 2, 1'b1, 1'b1, 0});
        tab.push_back(vec_t'{0, 3, 3, 1'b1, 1'b1, 0});
        tab.push_back(vec_t'{0, 4, 2, 1'b1, 1'b1, 1});
        tab.push_back(vec_t'{0, 2, 4, 1'b1, 1'b1, 6});
        tab.push_back(vec_t'{0, 5, 5, 1'b1, 1'b1, 7});
        tab.push_back(vec_t'{0, 13, 7, 1'b1, 1'b1, 17});
        tab.push_back(vec_t'{0, 14, 2, 1'b1, 1'b0, 0});
        tab.push_back(vec_t'{0, 2, 1, 1'b1, 1'b0, 0});
        tab.push_back(vec_t'{1, 5, 5, 1'b1, 1'b1, 25});
        tab.push_back(vec_t'{1, 3, 3, 1'b1, 1'b1, 18});

        repeat (3) @(negedge clk);
        model_reset();
        chk_reset("in_reset");
        rst = 1'b0;

        repeat (PIPE - 1) run_cycle(1'b0);
        chk("first_de_low", 32'(a_de), 0);
        run_cycle(1'b0);
        chk("first_de_rise", 32'({a_de, a_fs}), 32'h3);

        // Frame 0: request only in the swap cycle itself.
        while (k < FRAME) run_cycle(k % FRAME == SWAP_POS);
        chk("swap_in_cycle_part", 32'(a_read_part), 1);
        // Frame 1: single mid-frame pulse.
        while (k < 2 * FRAME) run_cycle(k % FRAME == 50);
        chk("mid_pulse_part", 32'(a_read_part), 2);
        tab_on = 1'b0;
        // Frame 2: a level plus extra pulses collapse into one swap; ring wraps.
        while (k < 3 * FRAME)
            run_cycle(((k % FRAME) >= 30 && (k % FRAME) < 41) || (k % FRAME) == 100 || (k % FRAME) == 200);
        chk("collapse_wrap_part", 32'(a_read_part), 0);
        // Frame 3: no request, only the frame counter moves.
        while (k < 4 * FRAME) run_cycle(1'b0);
        chk("no_req_part", 32'(a_read_part), 0);
        chk("no_req_fcount", 32'(a_frame_count), 4);

        while (k < 18 * FRAME) run_cycle($urandom_range(0, 199) == 0);

        // Reset mid-frame with a swap pending.
        while (k % FRAME != 3 * HMAX) run_cycle(1'b0);
        run_cycle(1'b1);
        while (k % FRAME != 5 * HMAX + 7) run_cycle(1'b0);
        rst = 1'b1;
        swap_req = 1'b0;
        #1;
        chk_reset("mid_reset");
        repeat (2) @(negedge clk);
        chk_reset("mid_reset_hold");
        model_reset();
        rst = 1'b0;
        while (k < 2 * FRAME) run_cycle(1'b0);
        chk("post_reset_part", 32'(a_read_part), 0);
        chk("post_reset_fcount", 32'(a_frame_count), 2);
        while (k < 3 * FRAME) run_cycle(k % FRAME == 77);
        chk("post_reset_swap_part", 32'(a_read_part), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
